// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader slice: FSM state encoding,
// instruction word width, address stride and parameter defaults.
package boot_pkg;

    localparam int                WORD_W              = 32;
    localparam logic [WORD_W-1:0] ADDR_INC            = 32'd4;
    localparam logic [WORD_W-1:0] BASE_ADDR_DEFAULT   = 32'h0000_0000;
    localparam int                DEPTH_DEFAULT       = 1024;
    localparam int                HOLD_CYCLES_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/boot_loader_if.sv
// Bus between the host/UART front end, the boot loader and the CPU top:
// the load stream handshake, the instruction-RAM debug write port and the
// core reset / status lines.
interface boot_loader_if;
    import boot_pkg::*;

    logic              start;
    logic              load_valid;
    logic [WORD_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              debug;
    logic              inst_ram_write_enable;
    logic [WORD_W-1:0] inst_ram_write_data;
    logic [WORD_W-1:0] inst_ram_write_address;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    // Host side: issues start and the word stream, observes everything else.
    modport master (
        output start, load_valid, load_data, load_last,
        input  load_ready, debug, inst_ram_write_enable, inst_ram_write_data,
        input  inst_ram_write_address, cpu_reset, busy, done, error
    );

    // Loader side.
    modport slave (
        input  start, load_valid, load_data, load_last,
        output load_ready, debug, inst_ram_write_enable, inst_ram_write_data,
        output inst_ram_write_address, cpu_reset, busy, done, error
    );

endinterface

// File: rtl/boot_loader_hold_timer.sv
// hold_timer: down-counter that measures how long the core stays in reset
// after loading. Loaded with HOLD_CYCLES, counts down to zero and holds there;
// o_expire is high while the count is zero.
module hold_timer
    import boot_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    output logic o_expire
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] r_count;

    // Reload on request, otherwise count down and stick at zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CW'(HOLD_CYCLES);
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_expire = (r_count == '0);

endmodule

// File: rtl/boot_loader.sv
// boot_loader: loads a program into the CPU instruction RAM through its debug
// write port while holding the core in reset, then releases the core after a
// settle interval.
// Optional feature: define BOOT_LOADER_CHECKSUM_EN to make the load_last beat
// a 32-bit wrapping checksum of the written words instead of a data word.
module boot_loader
    import boot_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int                DEPTH       = DEPTH_DEFAULT,
    parameter int                HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    boot_loader_if.slave bus
);

    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    state_t            r_state;
    logic              r_finish;      // last beat taken; one more LOAD cycle while its write is shown
    logic [CNT_W-1:0]  r_count;
    logic [WORD_W-1:0] r_addr;        // address for the next accepted word
    logic              r_load_ready;
    logic              r_debug;
    logic              r_we;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_waddr;
    logic              r_cpu_reset;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic w_accept;
    logic w_full;
    logic w_start_load;
    logic w_data_beat;    // accepted beat that becomes a RAM write
    logic w_err_beat;     // accepted beat that aborts the load
    logic w_last_ok;      // accepted beat that completes the load cleanly
    logic w_expire;

    assign w_accept     = bus.load_valid & r_load_ready;
    assign w_full       = (r_count == CNT_MAX);
    assign w_start_load = bus.start & (r_state inside {ST_IDLE, ST_RUN, ST_ERROR});

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] r_sum;

    // The last beat is a checksum: never written, and legal even when full.
    assign w_data_beat = w_accept & ~bus.load_last & ~w_full;
    assign w_err_beat  = w_accept & (bus.load_last ? (bus.load_data != r_sum) : w_full);
    assign w_last_ok   = w_accept & bus.load_last & (bus.load_data == r_sum);

    // Running wrap-around sum of every word written in the current load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= '0;
        end else if (w_start_load) begin
            r_sum <= '0;
        end else if (w_data_beat) begin
            r_sum <= r_sum + bus.load_data;
        end
    end
`else
    // The last beat is an ordinary word; a word arriving with the RAM full aborts.
    assign w_data_beat = w_accept & ~w_full;
    assign w_err_beat  = w_accept & w_full;
    assign w_last_ok   = w_accept & bus.load_last & ~w_full;
`endif

    // Timer is armed as the final beat is taken, so it has run down exactly as
    // HOLD ends (one drain cycle plus HOLD_CYCLES cycles of HOLD).
    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_load   (w_last_ok),
        .o_expire (w_expire)
    );

    // Sequencer FSM with its counters, write-port registers and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_finish     <= 1'b0;
            r_count      <= '0;
            r_addr       <= BASE_ADDR;
            r_load_ready <= 1'b0;
            r_debug      <= 1'b0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_waddr      <= BASE_ADDR;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    if (bus.start) begin
                        r_state      <= ST_LOAD;
                        r_finish     <= 1'b0;
                        r_count      <= '0;
                        r_addr       <= BASE_ADDR;
                        r_waddr      <= BASE_ADDR;
                        r_load_ready <= 1'b1;
                        r_debug      <= 1'b1;
                        r_cpu_reset  <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (r_finish) begin
                        // Final write has been shown with debug high; hand over to HOLD.
                        r_state  <= ST_HOLD;
                        r_finish <= 1'b0;
                        r_debug  <= 1'b0;
                    end else if (w_err_beat) begin
                        r_state      <= ST_ERROR;
                        r_load_ready <= 1'b0;
                        r_debug      <= 1'b0;
                        r_busy       <= 1'b0;
                        r_error      <= 1'b1;
                    end else begin
                        if (w_data_beat) begin
                            r_we    <= 1'b1;
                            r_wdata <= bus.load_data;
                            r_waddr <= r_addr;
                            r_addr  <= r_addr + ADDR_INC;
                            r_count <= r_count + CNT_W'(1);
                        end
                        if (w_last_ok) begin
                            r_finish     <= 1'b1;
                            r_load_ready <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_expire) begin
                        r_state     <= ST_RUN;
                        r_cpu_reset <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.load_ready             = r_load_ready;
    assign bus.debug                  = r_debug;
    assign bus.inst_ram_write_enable  = r_we;
    assign bus.inst_ram_write_data    = r_wdata;
    assign bus.inst_ram_write_address = r_waddr;
    assign bus.cpu_reset              = r_cpu_reset;
    assign bus.busy                   = r_busy;
    assign bus.done                   = r_done;
    assign bus.error                  = r_error;

endmodule

// File: doc/boot_loader.md
# boot_loader

Sequencer that brings the CPU out of reset with a freshly loaded program. It accepts a stream of 32-bit instruction words over a valid/ready handshake and drives the CPU's instruction-RAM debug write port (`debug`, `inst_ram_write_enable`, `inst_ram_write_data`, `inst_ram_write_address`) while holding the core in reset. After a programmable settle interval, it releases the core. It sits between the host/UART front end and the CPU top level, and is the only owner of the CPU's reset and debug inputs.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first loaded word.
- `DEPTH`, default 1024: maximum number of words per load.
- `HOLD_CYCLES`, default 8: cycles `cpu_reset` stays high after loading ends with `debug` low; must be ≥1.

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a load.
- `load_valid`  in  1  word available.
- `load_data`  in  32  instruction word.
- `load_last`  in  1  qualifies the final beat.
- `load_ready`  out  1  loader accepts a beat this cycle.
- `debug`  out  1  selects the debug address into the instruction RAM.
- `inst_ram_write_enable`  out  1  write strobe.
- `inst_ram_write_data`  out  32  word to write.
- `inst_ram_write_address`  out  32  byte address.
- `cpu_reset`  out  1  active-high hold of the core.
- `busy`  out  1  in LOAD or HOLD.
- `done`  out  1  in RUN.
- `error`  out  1  in ERROR; sticky until `start` or `reset`.

## Operation
- **States:** IDLE, LOAD, HOLD, RUN, ERROR.
- **IDLE:** `cpu_reset`=1, `debug`=0. On `start`, go to LOAD. Also clear the word count, set the address to `BASE_ADDR`, and clear the checksum.
- **LOAD:** `debug`=1, `load_ready`=1.
  - A beat is accepted when `load_valid & load_ready`.
  - Each accepted data beat produces exactly one write of `load_data` to the current address. After the write, the address advances by 4 and the count by 1.
  - An accepted beat with `load_last` goes to HOLD.
- **Overflow:** if `DEPTH` words have been written and a further beat is accepted without `load_last`, go to ERROR. That beat is not written.
- **HOLD:** `debug`=0, `cpu_reset`=1. Count `HOLD_CYCLES`, then go to RUN.
- **RUN:** `cpu_reset`=0, `done`=1. On `start`, go back to LOAD, which re-asserts `cpu_reset` (reload).
- **ERROR:** `cpu_reset`=1, `debug`=0. Only `start` or `reset` leaves ERROR; `start` goes to LOAD.
- **Address arithmetic:** 32-bit and wraps modulo 2^32; no other check.
- `start` while in LOAD or HOLD is ignored.
- `load_valid` outside LOAD is ignored, because `load_ready`=0.

## Timing
- **Reset values:** state IDLE, `cpu_reset`=1, `debug`=0, `inst_ram_write_enable`=0, `inst_ram_write_data`=0, `inst_ram_write_address`=`BASE_ADDR`, `load_ready`=0, `busy`=0, `done`=0, `error`=0.
- All outputs are registered.
- **Write latency:** the write is presented in the cycle after the beat is accepted. `inst_ram_write_enable` pulses for one cycle per word, with data and address stable in that same cycle.
- `debug` stays high through the cycle of the last write. It falls in the first HOLD cycle.
- `start` in IDLE → `load_ready`=1 on the next cycle.
- `load_ready` is high continuously in LOAD, so back-to-back beats are sustained at one word per cycle.
- `load_ready` drops in the cycle after the last beat.
- Last write cycle → `cpu_reset` falls exactly `HOLD_CYCLES`+1 cycles later.
- **Reset mid-operation:** `reset` in any state returns to the reset values on the next edge. A write in flight is dropped.
- `reset` and `start` in the same cycle: `reset` wins.

## Configuration
- **Macro:** `BOOT_LOADER_CHECKSUM_EN`.
- **Defined:** the `load_last` beat carries a checksum and is not written.
  - The checksum is the 32-bit wrapping sum of all written words.
  - Match → HOLD. Mismatch → ERROR, with `cpu_reset` kept high.
  - A `load_last` beat accepted after `DEPTH` data words is legal.
- **Undefined:** the `load_last` beat is an ordinary data word. It is written, and there is no checksum logic.

## Structure
- Package `boot_pkg` holds:
  - the state enum;
  - the word width constant (32);
  - the address increment (4);
  - the parameter defaults.
- Sub-module `hold_timer`:
  - a down-counter loaded with `HOLD_CYCLES` on entry to HOLD;
  - asserts `expire` when it reaches 0;
  - cleared by `reset`.
- Everything else lives in `boot_loader`: the FSM, counters, write registers, and the checksum.

## Test plan
- **Basic load:** reset, then `start`, then 3 back-to-back beats 32'h2408_0001, 32'h2409_0002, 32'h0109_5020 with `load_last` on the third (macro off). Expect writes to addresses 0x0, 0x4, 0x8 on consecutive cycles. Then `debug` low, `cpu_reset` low 9 cycles after the last write (`HOLD_CYCLES`=8), and `done`=1.
- **Gapped valid:** the same 3 words with `load_valid` toggling every other cycle. Expect the same writes, addresses and order, and no duplicate writes.
- **Overflow:** `DEPTH`=4, 5 beats with none marked last. Expect 4 writes, no write on beat 5, then ERROR with `error`=1 and `cpu_reset`=1. A later `start` clears `error`.
- **Checksum (macro on):** words 1, 2, 3, then last beat = 6. Expect 3 writes and RUN. Repeat with last beat = 7: expect ERROR, `cpu_reset` stays 1.
- **Reset mid-load:** assert `reset` after 2 of 4 beats. The next cycle shows all reset values. A fresh `start` rewrites from `BASE_ADDR`.
- **Reload from RUN:** `start` in RUN. `cpu_reset` rises in the next cycle, `debug`=1, and the address restarts at `BASE_ADDR`.
